// File: rtl/pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pio_pkg
//  Description : Shared constants for the programmable parallel I/O block:
//                CFG bit positions, direction/mode encodings, address offsets.
//  Revision    : 1.0  initial release
// ============================================================================
package pio_pkg;

    localparam int C_CFG_W    = 3;
    localparam int C_CFG_DIR  = 0;
    localparam int C_CFG_MODE = 1;
    localparam int C_CFG_IE   = 2;

    typedef enum logic {
        DIR_OUT = 1'b0,
        DIR_IN  = 1'b1
    } pio_dir_e;

    typedef enum logic {
        MODE_BASIC   = 1'b0,
        MODE_STROBED = 1'b1
    } pio_mode_e;

    // Offsets are relative to NPORT; data ports occupy 0..NPORT-1.
    localparam int C_ADDR_PC_OFS   = 0;
    localparam int C_ADDR_CTRL_OFS = 1;
    localparam int C_ADDR_CFG_OFS  = 2;

endpackage
`default_nettype wire

// File: rtl/pio_port.sv
`default_nettype none
// ============================================================================
//  Module      : pio_port
//  Description : One handshake-capable data port: output latch, strobed input
//                buffer, stb/ack edge detect, ibf/obf/overrun and interrupt.
//  Revision    : 1.0  initial release
// ============================================================================
module pio_port
    import pio_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_cfg_we,
    input  logic [C_CFG_W-1:0] i_cfg,
    input  logic               i_wr,
    input  logic               i_rd,
    input  logic [DW-1:0]      i_din,
    input  logic [DW-1:0]      i_pin,
    input  logic               i_stb_n,
    input  logic               i_ack_n,
    input  logic               i_ovr_clr,
    output logic [C_CFG_W-1:0] o_cfg,
    output logic [DW-1:0]      o_rdata,
    output logic [DW-1:0]      o_latch,
    output logic [DW-1:0]      o_oe,
    output logic               o_ibf,
    output logic               o_obf,
    output logic               o_ovr,
    output logic               o_intr
);

    logic [C_CFG_W-1:0] r_cfg;
    logic [DW-1:0]      r_latch;
    logic [DW-1:0]      r_buf;
    logic               r_ibf;
    logic               r_obf;
    logic               r_ovr;
    logic               r_intr;
    logic               r_stb_q;
    logic               r_ack_q;
    logic               r_armed;

    pio_dir_e           w_dir;
    pio_mode_e          w_mode;
    logic               w_strb_in;
    logic               w_strb_out;
    logic               w_stb_fall;
    logic               w_ack_fall;
    logic [C_CFG_W-1:0] w_cfg_nx;
    logic [DW-1:0]      w_latch_nx;
    logic [DW-1:0]      w_buf_nx;
    logic               w_ibf_nx;
    logic               w_obf_nx;
    logic               w_ovr_nx;
    logic               w_intr_nx;

    assign w_dir      = pio_dir_e'(r_cfg[C_CFG_DIR]);
    assign w_mode     = pio_mode_e'(r_cfg[C_CFG_MODE]);
    assign w_strb_in  = (w_mode == MODE_STROBED) && (w_dir == DIR_IN);
    assign w_strb_out = (w_mode == MODE_STROBED) && (w_dir == DIR_OUT);
    // r_armed masks the first cycle after reset so a low pin is not seen as a fall.
    assign w_stb_fall = r_armed & r_stb_q & ~i_stb_n;
    assign w_ack_fall = r_armed & r_ack_q & ~i_ack_n;
    assign w_cfg_nx   = i_cfg_we ? i_cfg : r_cfg;

    always_comb begin
        w_latch_nx = r_latch;
        w_buf_nx   = r_buf;
        w_ibf_nx   = r_ibf;
        w_obf_nx   = r_obf;
        w_ovr_nx   = r_ovr;
        if (i_ovr_clr) begin
            w_ovr_nx = 1'b0;
        end
        if (i_cfg_we) begin
            w_latch_nx = '0;
            w_ibf_nx   = 1'b0;
            w_obf_nx   = 1'b0;
            w_ovr_nx   = 1'b0;
        end else begin
            if (i_wr) begin
                w_latch_nx = i_din;
            end
            if (w_strb_in) begin
                if (i_rd) begin
                    w_ibf_nx = 1'b0;
                end
                // A read in the same cycle frees the buffer for the new sample.
                if (w_stb_fall) begin
                    if (r_ibf && !i_rd) begin
                        w_ovr_nx = 1'b1;
                    end else begin
                        w_buf_nx = i_pin;
                        w_ibf_nx = 1'b1;
                    end
                end
            end
            if (w_strb_out) begin
                if (w_ack_fall) begin
                    w_obf_nx = 1'b0;
                end
                if (i_wr) begin
                    w_obf_nx = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_intr_nx = 1'b0;
        if (w_cfg_nx[C_CFG_MODE] == MODE_STROBED) begin
            if (w_cfg_nx[C_CFG_DIR] == DIR_IN) begin
                w_intr_nx = w_cfg_nx[C_CFG_IE] & w_ibf_nx;
            end else begin
                w_intr_nx = w_cfg_nx[C_CFG_IE] & ~w_obf_nx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg   <= '0;
            r_latch <= '0;
            r_buf   <= '0;
            r_ibf   <= 1'b0;
            r_obf   <= 1'b0;
            r_ovr   <= 1'b0;
            r_intr  <= 1'b0;
            r_stb_q <= 1'b1;
            r_ack_q <= 1'b1;
            r_armed <= 1'b0;
        end else begin
            r_cfg   <= w_cfg_nx;
            r_latch <= w_latch_nx;
            r_buf   <= w_buf_nx;
            r_ibf   <= w_ibf_nx;
            r_obf   <= w_obf_nx;
            r_ovr   <= w_ovr_nx;
            r_intr  <= w_intr_nx;
            r_stb_q <= i_stb_n;
            r_ack_q <= i_ack_n;
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        o_rdata = r_latch;
        if (w_dir == DIR_IN) begin
            o_rdata = (w_mode == MODE_STROBED) ? r_buf : i_pin;
        end
    end

    assign o_cfg   = r_cfg;
    assign o_latch = r_latch;
    assign o_oe    = (w_dir == DIR_IN) ? '0 : '1;
    assign o_ibf   = r_ibf;
    assign o_obf   = r_obf;
    assign o_ovr   = r_ovr;
    assign o_intr  = r_intr;

endmodule
`default_nettype wire

// File: rtl/prog_pio.sv
`default_nettype none
// ============================================================================
//  Module      : prog_pio
//  Description : Programmable parallel I/O: bus decode, NPORT data ports,
//                port C with bit set/reset, status register and read mux.
//  Revision    : 1.0  initial release
// ============================================================================
module prog_pio
    import pio_pkg::*;
#(
    parameter  int DW    = 8,
    parameter  int NPORT = 2,
    localparam int AW    = $clog2(2*NPORT+2)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cs_n,
    input  logic                rd_n,
    input  logic                wr_n,
    input  logic [AW-1:0]       addr,
    input  logic [DW-1:0]       din,
    output logic [DW-1:0]       dout,
    input  logic [NPORT*DW-1:0] port_in,
    output logic [NPORT*DW-1:0] port_out,
    output logic [NPORT*DW-1:0] port_oe,
    input  logic [NPORT-1:0]    stb_n,
    input  logic [NPORT-1:0]    ack_n,
    output logic [NPORT-1:0]    ibf,
    output logic [NPORT-1:0]    obf_n,
    output logic [NPORT-1:0]    intr,
    output logic [DW-1:0]       pc_out,
    output logic [DW-1:0]       pc_oe,
    input  logic [DW-1:0]       pc_in
);

    localparam int BW = $clog2(DW);
    localparam int HW = DW / 2;

    logic [DW-1:0]      r_dout;
    logic [DW-1:0]      r_pc_out;
    logic [DW-1:0]      r_pc_oe;

    logic               w_wr;
    logic               w_rd;
    logic               w_sel_pc;
    logic               w_sel_ctrl;
    logic [NPORT-1:0]   w_obf;
    logic [NPORT-1:0]   w_ovr;
    logic [NPORT-1:0]   w_flag;
    logic [DW-1:0]      w_status;
    logic [DW-1:0]      w_rdata;
    logic [DW-1:0]      w_port_rdata [NPORT];
    logic [C_CFG_W-1:0] w_port_cfg   [NPORT];

    // A simultaneous rd strobe during a write is ignored.
    assign w_wr       = ~cs_n & ~wr_n;
    assign w_rd       = ~cs_n & ~rd_n & wr_n;
    assign w_sel_pc   = (addr == AW'(NPORT + C_ADDR_PC_OFS));
    assign w_sel_ctrl = (addr == AW'(NPORT + C_ADDR_CTRL_OFS));

    generate
        for (genvar i = 0; i < NPORT; i++) begin : g_port
            logic w_sel_data;
            logic w_sel_cfg;

            assign w_sel_data = (addr == AW'(i));
            assign w_sel_cfg  = (addr == AW'(NPORT + C_ADDR_CFG_OFS + i));

            pio_port #(
                .DW (DW)
            ) u_port (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_cfg_we  (w_wr & w_sel_cfg),
                .i_cfg     (din[C_CFG_W-1:0]),
                .i_wr      (w_wr & w_sel_data),
                .i_rd      (w_rd & w_sel_data),
                .i_din     (din),
                .i_pin     (port_in[i*DW +: DW]),
                .i_stb_n   (stb_n[i]),
                .i_ack_n   (ack_n[i]),
                .i_ovr_clr (w_rd & w_sel_ctrl),
                .o_cfg     (w_port_cfg[i]),
                .o_rdata   (w_port_rdata[i]),
                .o_latch   (port_out[i*DW +: DW]),
                .o_oe      (port_oe[i*DW +: DW]),
                .o_ibf     (ibf[i]),
                .o_obf     (w_obf[i]),
                .o_ovr     (w_ovr[i]),
                .o_intr    (intr[i])
            );

            assign w_flag[i] = w_port_cfg[i][C_CFG_DIR] ? ibf[i] : w_obf[i];
            assign obf_n[i]  = ~w_obf[i];
        end
    endgenerate

    assign w_status = DW'({w_ovr, w_flag});

    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (addr == AW'(k)) begin
                w_rdata = w_port_rdata[k];
            end
            if (addr == AW'(NPORT + C_ADDR_CFG_OFS + k)) begin
                w_rdata = DW'(w_port_cfg[k]);
            end
        end
        if (w_sel_pc) begin
            w_rdata = (r_pc_out & r_pc_oe) | (pc_in & ~r_pc_oe);
        end
        if (w_sel_ctrl) begin
            w_rdata = w_status;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else if (w_rd) begin
            r_dout <= w_rdata;
        end
    end

    // CTRL with MSB set programs half-port directions; MSB clear is a single-bit set/reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_out <= '0;
            r_pc_oe  <= '0;
        end else if (w_wr && w_sel_ctrl) begin
            if (din[DW-1]) begin
                r_pc_oe <= {{(DW-HW){din[1]}}, {HW{din[0]}}};
            end else begin
                r_pc_out[din[BW:1]] <= din[0];
            end
        end else if (w_wr && w_sel_pc) begin
            r_pc_out <= din;
        end
    end

    assign dout   = r_dout;
    assign pc_out = r_pc_out;
    assign pc_oe  = r_pc_oe;

endmodule
`default_nettype wire

// File: tb/tb_prog_pio.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_prog_pio
//  Description : Self-checking bench for prog_pio (DW=8, NPORT=2) against a
//                transaction-level model of ports, handshakes and port C.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prog_pio;

    localparam int DW    = 8;
    localparam int NPORT = 2;
    localparam int AW    = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cs_n, rd_n, wr_n;
    logic [AW-1:0]       addr;
    logic [DW-1:0]       din, dout;
    logic [NPORT*DW-1:0] port_in, port_out, port_oe;
    logic [NPORT-1:0]    stb_n, ack_n, ibf, obf_n, intr;
    logic [DW-1:0]       pc_out, pc_oe, pc_in;

    always #5 clk = ~clk;

    prog_pio #(.DW(DW), .NPORT(NPORT)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .addr(addr), .din(din), .dout(dout), .port_in(port_in),
        .port_out(port_out), .port_oe(port_oe), .stb_n(stb_n), .ack_n(ack_n),
        .ibf(ibf), .obf_n(obf_n), .intr(intr), .pc_out(pc_out), .pc_oe(pc_oe),
        .pc_in(pc_in)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0]    m_cfg   [NPORT];
    logic [DW-1:0] m_latch [NPORT];
    logic [DW-1:0] m_buf   [NPORT];
    logic          m_ibf   [NPORT];
    logic          m_obf   [NPORT];
    logic          m_ovr   [NPORT];
    logic [DW-1:0] m_pc_out, m_pc_oe;

    function automatic bit strobed_in(int p);  return m_cfg[p][1] &&  m_cfg[p][0]; endfunction
    function automatic bit strobed_out(int p); return m_cfg[p][1] && !m_cfg[p][0]; endfunction

    function automatic void m_reset();
        for (int p = 0; p < NPORT; p++) begin
            m_cfg[p] = 3'd0; m_latch[p] = '0; m_buf[p] = '0;
            m_ibf[p] = 1'b0; m_obf[p] = 1'b0; m_ovr[p] = 1'b0;
        end
        m_pc_out = '0; m_pc_oe = '0;
    endfunction

    function automatic void m_write(int a, logic [DW-1:0] d);
        if (a < NPORT) begin
            m_latch[a] = d;
            if (strobed_out(a)) m_obf[a] = 1'b1;
        end else if (a == NPORT + 1) begin
            if (d[DW-1]) m_pc_oe = {{4{d[1]}}, {4{d[0]}}};
            else         m_pc_out[d[3:1]] = d[0];
        end else if (a >= NPORT + 2 && a < 2*NPORT + 2) begin
            m_cfg[a-NPORT-2] = d[2:0]; m_latch[a-NPORT-2] = '0;
            m_ibf[a-NPORT-2] = 1'b0; m_obf[a-NPORT-2] = 1'b0; m_ovr[a-NPORT-2] = 1'b0;
        end
    endfunction

    function automatic logic [DW-1:0] exp_read(int a);
        logic [DW-1:0] r;
        r = '0;
        if (a < NPORT) begin
            if (!m_cfg[a][0])     r = m_latch[a];
            else if (m_cfg[a][1]) r = m_buf[a];
            else                  r = port_in[a*DW +: DW];
        end else if (a == NPORT) begin
            r = (m_pc_out & m_pc_oe) | (pc_in & ~m_pc_oe);
        end else if (a == NPORT + 1) begin
            for (int p = 0; p < NPORT; p++) begin
                r[p]       = m_cfg[p][0] ? m_ibf[p] : m_obf[p];
                r[NPORT+p] = m_ovr[p];
            end
        end else if (a < 2*NPORT + 2) begin
            r = DW'(m_cfg[a-NPORT-2]);
        end
        return r;
    endfunction

    function automatic void m_read_side(int a);
        if (a < NPORT && strobed_in(a)) m_ibf[a] = 1'b0;
        if (a == NPORT + 1) for (int p = 0; p < NPORT; p++) m_ovr[p] = 1'b0;
    endfunction

    function automatic void m_stb(int p, logic [DW-1:0] d);
        if (strobed_in(p)) begin
            if (m_ibf[p]) m_ovr[p] = 1'b1;
            else begin m_buf[p] = d; m_ibf[p] = 1'b1; end
        end
    endfunction

    function automatic logic [NPORT*DW-1:0] exp_port_out();
        for (int p = 0; p < NPORT; p++) exp_port_out[p*DW +: DW] = m_latch[p];
    endfunction
    function automatic logic [NPORT*DW-1:0] exp_port_oe();
        for (int p = 0; p < NPORT; p++) exp_port_oe[p*DW +: DW] = m_cfg[p][0] ? '0 : '1;
    endfunction
    function automatic logic [NPORT-1:0] exp_ibf();
        for (int p = 0; p < NPORT; p++) exp_ibf[p] = m_ibf[p];
    endfunction
    function automatic logic [NPORT-1:0] exp_obf_n();
        for (int p = 0; p < NPORT; p++) exp_obf_n[p] = ~m_obf[p];
    endfunction
    function automatic logic [NPORT-1:0] exp_intr();
        for (int p = 0; p < NPORT; p++)
            exp_intr[p] = m_cfg[p][2] & (strobed_in(p) ? m_ibf[p] : strobed_out(p) ? ~m_obf[p] : 1'b0);
    endfunction

    task automatic bus_write(input int a, input logic [DW-1:0] d);
        @(negedge clk); cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1; addr = AW'(a); din = d;
        @(negedge clk); cs_n = 1'b1; wr_n = 1'b1;
        m_write(a, d);
    endtask

    task automatic bus_read(input int a, output logic [DW-1:0] got, output logic [DW-1:0] exp);
        @(negedge clk); cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; addr = AW'(a);
        exp = exp_read(a);
        m_read_side(a);
        @(negedge clk); cs_n = 1'b1; rd_n = 1'b1;
        got = dout;
    endtask

    task automatic pulse_stb(input int p, input logic [DW-1:0] d);
        @(negedge clk); port_in[p*DW +: DW] = d; stb_n[p] = 1'b0;
        @(negedge clk); stb_n[p] = 1'b1;
        m_stb(p, d);
    endtask

    task automatic pulse_ack(input int p);
        @(negedge clk); ack_n[p] = 1'b0;
        @(negedge clk); ack_n[p] = 1'b1;
        if (strobed_out(p)) m_obf[p] = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout got %h exp 00", dout); end
        n_tests++; if (port_out !== '0) begin n_fail++; $display("FAIL reset_port_out got %h exp 0000", port_out); end
        n_tests++; if (port_oe !== '1) begin n_fail++; $display("FAIL reset_port_oe got %h exp ffff", port_oe); end
        n_tests++; if ({ibf, intr} !== '0) begin n_fail++; $display("FAIL reset_ibf_intr got %b exp 0000", {ibf, intr}); end
        n_tests++; if (obf_n !== '1) begin n_fail++; $display("FAIL reset_obf_n got %b exp 11", obf_n); end
        n_tests++; if ({pc_out, pc_oe} !== '0) begin n_fail++; $display("FAIL reset_pc got %h exp 0000", {pc_out, pc_oe}); end
    endtask

    task automatic test_basic_output();
        logic [DW-1:0] got, exp, d, held;
        bus_write(4, 8'h00);
        bus_write(0, 8'hA5);
        n_tests++; if (port_out !== exp_port_out()) begin n_fail++; $display("FAIL bo_a5_port_out got %h exp %h", port_out, exp_port_out()); end
        n_tests++; if (port_oe !== exp_port_oe()) begin n_fail++; $display("FAIL bo_port_oe got %h exp %h", port_oe, exp_port_oe()); end
        bus_read(0, got, exp);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL bo_a5_read got %h exp %h", got, exp); end
        for (int i = 0; i < 4; i++) begin
            d = DW'($urandom);
            bus_write(i % NPORT, d);
            n_tests++; if (port_out !== exp_port_out()) begin n_fail++; $display("FAIL bo_rand_port_out got %h exp %h", port_out, exp_port_out()); end
            bus_read(i % NPORT, got, exp);
            n_tests++; if (got !== exp) begin n_fail++; $display("FAIL bo_rand_read got %h exp %h", got, exp); end
        end
        held = dout;
        // Write with rd_n also low: the read is ignored, dout holds.
        d = ~held;
        @(negedge clk); cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; addr = AW'(0); din = d;
        @(negedge clk); cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        m_write(0, d);
        n_tests++; if (dout !== held) begin n_fail++; $display("FAIL wr_rd_dout_hold got %h exp %h", dout, held); end
        n_tests++; if (port_out !== exp_port_out()) begin n_fail++; $display("FAIL wr_rd_port_out got %h exp %h", port_out, exp_port_out()); end
    endtask

    task automatic test_basic_input();
        logic [DW-1:0] got, exp;
        bus_write(5, 8'h01);
        n_tests++; if (port_oe !== exp_port_oe()) begin n_fail++; $display("FAIL bi_port_oe got %h exp %h", port_oe, exp_port_oe()); end
        for (int i = 0; i < 3; i++) begin
            port_in = (NPORT*DW)'($urandom);
            bus_read(1, got, exp);
            n_tests++; if (got !== exp) begin n_fail++; $display("FAIL bi_read got %h exp %h", got, exp); end
        end
        bus_read(5, got, exp);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL cfg_readback got %h exp %h", got, exp); end
    endtask

    task automatic test_strobed_input();
        logic [DW-1:0] got, exp, d;
        bus_write(5, 8'h07);
        for (int i = 0; i < 3; i++) begin
            d = (i == 0) ? 8'h3C : DW'($urandom);
            pulse_stb(1, d);
            n_tests++; if (ibf !== exp_ibf() || intr !== exp_intr()) begin n_fail++; $display("FAIL si_flags got ibf=%b intr=%b exp ibf=%b intr=%b", ibf, intr, exp_ibf(), exp_intr()); end
            port_in[DW +: DW] = ~d;
            bus_read(1, got, exp);
            n_tests++; if (got !== exp) begin n_fail++; $display("FAIL si_read got %h exp %h", got, exp); end
            n_tests++; if (ibf !== exp_ibf() || intr !== exp_intr()) begin n_fail++; $display("FAIL si_clear got ibf=%b intr=%b exp ibf=%b intr=%b", ibf, intr, exp_ibf(), exp_intr()); end
        end
    endtask

    task automatic test_overrun();
        logic [DW-1:0] got, exp, a, b;
        pulse_stb(1, 8'h11);
        pulse_stb(1, 8'h22);
        bus_read(1, got, exp);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL ovr_read got %h exp %h", got, exp); end
        bus_read(3, got, exp);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL ovr_status1 got %h exp %h", got, exp); end
        bus_read(3, got, exp);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL ovr_status2 got %h exp %h", got, exp); end
        // Status read coinciding with a fresh overrun: the new overrun survives.
        a = DW'($urandom); b = DW'($urandom);
        pulse_stb(1, a);
        pulse_stb(1, b);
        @(negedge clk); cs_n = 1'b0; rd_n = 1'b0; addr = AW'(3); port_in[DW +: DW] = ~b; stb_n[1] = 1'b0;
        exp = exp_read(3); m_read_side(3); m_stb(1, ~b);
        @(negedge clk); cs_n = 1'b1; rd_n = 1'b1; stb_n[1] = 1'b1;
        n_tests++; if (dout !== exp) begin n_fail++; $display("FAIL ovr_status_same got %h exp %h", dout, exp); end
        bus_read(3, got, exp);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL ovr_sticky got %h exp %h", got, exp); end
        bus_read(1, got, exp);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL ovr_buf_kept got %h exp %h", got, exp); end
    endtask

    task automatic test_stb_read_same();
        logic [DW-1:0] got, exp, a, b;
        a = DW'($urandom); b = ~a;
        pulse_stb(1, a);
        @(negedge clk); cs_n = 1'b0; rd_n = 1'b0; addr = AW'(1); port_in[DW +: DW] = b; stb_n[1] = 1'b0;
        exp = exp_read(1); m_read_side(1); m_stb(1, b);
        @(negedge clk); cs_n = 1'b1; rd_n = 1'b1; stb_n[1] = 1'b1;
        n_tests++; if (dout !== exp) begin n_fail++; $display("FAIL same_old_data got %h exp %h", dout, exp); end
        n_tests++; if (ibf !== exp_ibf()) begin n_fail++; $display("FAIL same_ibf got %b exp %b", ibf, exp_ibf()); end
        bus_read(1, got, exp);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL same_new_data got %h exp %h", got, exp); end
        bus_read(3, got, exp);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL same_no_ovr got %h exp %h", got, exp); end
    endtask

    task automatic test_strobed_output();
        logic [DW-1:0] got, exp, d;
        bus_write(4, 8'h06);
        n_tests++; if (obf_n !== exp_obf_n() || intr !== exp_intr()) begin n_fail++; $display("FAIL so_cfg got obf_n=%b intr=%b exp obf_n=%b intr=%b", obf_n, intr, exp_obf_n(), exp_intr()); end
        bus_write(0, 8'h5A);
        n_tests++; if (obf_n !== exp_obf_n() || intr !== exp_intr() || port_out !== exp_port_out()) begin n_fail++; $display("FAIL so_write got obf_n=%b intr=%b out=%h exp obf_n=%b intr=%b out=%h", obf_n, intr, port_out, exp_obf_n(), exp_intr(), exp_port_out()); end
        bus_read(3, got, exp);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL so_status got %h exp %h", got, exp); end
        pulse_ack(0);
        n_tests++; if (obf_n !== exp_obf_n() || intr !== exp_intr()) begin n_fail++; $display("FAIL so_ack got obf_n=%b intr=%b exp obf_n=%b intr=%b", obf_n, intr, exp_obf_n(), exp_intr()); end
        bus_write(0, DW'($urandom));
        d = DW'($urandom);
        @(negedge clk); cs_n = 1'b0; wr_n = 1'b0; addr = AW'(0); din = d; ack_n[0] = 1'b0;
        @(negedge clk); cs_n = 1'b1; wr_n = 1'b1; ack_n[0] = 1'b1;
        m_write(0, d);
        n_tests++; if (obf_n !== exp_obf_n() || port_out !== exp_port_out()) begin n_fail++; $display("FAIL so_write_wins got obf_n=%b out=%h exp obf_n=%b out=%h", obf_n, port_out, exp_obf_n(), exp_port_out()); end
        bus_write(4, 8'h00);
        n_tests++; if (obf_n !== exp_obf_n() || port_out !== exp_port_out()) begin n_fail++; $display("FAIL cfg_clears got obf_n=%b out=%h exp obf_n=%b out=%h", obf_n, port_out, exp_obf_n(), exp_port_out()); end
    endtask

    task automatic test_portc();
        logic [DW-1:0] got, exp, d;
        logic [DW-1:0] seq [4] = '{8'h07, 8'h0F, 8'h0E, 8'h0F};
        bus_write(3, 8'h83);
        n_tests++; if (pc_oe !== m_pc_oe) begin n_fail++; $display("FAIL pc_oe got %h exp %h", pc_oe, m_pc_oe); end
        for (int i = 0; i < 4; i++) begin
            bus_write(3, seq[i]);
            n_tests++; if (pc_out !== m_pc_out) begin n_fail++; $display("FAIL bsr_seq got %h exp %h", pc_out, m_pc_out); end
        end
        for (int i = 0; i < 6; i++) begin
            d = DW'($urandom) & 8'h7F;
            bus_write(3, d);
            n_tests++; if (pc_out !== m_pc_out) begin n_fail++; $display("FAIL bsr_rand got %h exp %h", pc_out, m_pc_out); end
        end
        bus_write(3, 8'h81);
        for (int i = 0; i < 2; i++) begin
            pc_in = DW'($urandom);
            bus_read(2, got, exp);
            n_tests++; if (got !== exp) begin n_fail++; $display("FAIL pc_read got %h exp %h", got, exp); end
        end
    endtask

    task automatic test_bad_addr();
        logic [DW-1:0] got, exp;
        for (int a = 2*NPORT + 2; a < 8; a++) begin
            bus_write(a, 8'hFF);
            bus_read(a, got, exp);
            n_tests++; if (got !== exp) begin n_fail++; $display("FAIL bad_addr_read got %h exp %h", got, exp); end
            n_tests++; if (port_out !== exp_port_out() || pc_out !== m_pc_out || pc_oe !== m_pc_oe) begin n_fail++; $display("FAIL bad_addr_write got %h/%h/%h exp %h/%h/%h", port_out, pc_out, pc_oe, exp_port_out(), m_pc_out, m_pc_oe); end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] got, exp;
        bus_write(0, 8'hC3);
        bus_write(5, 8'h07);
        pulse_stb(1, 8'h96);
        @(negedge clk); stb_n[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (ibf !== '0) begin n_fail++; $display("FAIL post_reset_ibf got %b exp 00", ibf); end
        stb_n[1] = 1'b1;
        bus_write(5, 8'h03);
        bus_read(1, got, exp);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL post_reset_buf got %h exp %h", got, exp); end
    endtask

    initial begin
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = '0; din = '0;
        port_in = '0; pc_in = '0; stb_n = '1; ack_n = '1;
        m_reset();
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic_output();
        test_basic_input();
        test_strobed_input();
        test_overrun();
        test_stb_read_same();
        test_strobed_output();
        test_portc();
        test_bad_addr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
`default_nettype wire
